// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
//
// Purpose:
//   Shared definitions for the branch-direction predictor slice.
//   Provides the indexing-mode encodings and the saturating-counter helpers
//   used by every counter in the table.
//
// Contents:
//   bp_mode_e    - indexing mode: BP_BIMODAL (PC only) or BP_GSHARE (PC ^ GHR)
//   bp_ctr_t     - widest supported counter; narrower counters are
//                  zero-extended into it before calling the helpers
//   bp_sat_inc   - increment, saturating at 2^width-1
//   bp_sat_dec   - decrement, saturating at 0
//   bp_taken     - predicted direction (MSB of a width-bit counter)
// ---------------------------------------------------------------------------
package bp_pkg;

    typedef enum int {
        BP_BIMODAL = 0,
        BP_GSHARE  = 1
    } bp_mode_e;

    localparam int BP_CTR_MAX_W = 4;

    typedef logic [BP_CTR_MAX_W-1:0] bp_ctr_t;

    // Largest value a width-bit counter can hold.
    function automatic bp_ctr_t bp_ctr_max(input int unsigned width);
        return bp_ctr_t'((32'd1 << width) - 32'd1);
    endfunction

    function automatic bp_ctr_t bp_sat_inc(input bp_ctr_t ctr, input int unsigned width);
        bp_ctr_t top;
        top = bp_ctr_max(width);
        return (ctr >= top) ? top : ctr + bp_ctr_t'(1);
    endfunction

    function automatic bp_ctr_t bp_sat_dec(input bp_ctr_t ctr, input int unsigned width);
        return (ctr == '0) ? '0 : ctr - bp_ctr_t'(1);
    endfunction

    function automatic logic bp_taken(input bp_ctr_t ctr, input int unsigned width);
        logic [1:0] msb;
        msb = 2'(width - 32'd1);
        return ctr[msb];
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// ---------------------------------------------------------------------------
// bp_sat_ctr
//
// Purpose:
//   One CTR_W-bit saturating up/down counter. Counts up when enabled with
//   up_i=1, down when enabled with up_i=0, never wraps in either direction.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset, clears the counter to 0
//   en_i     in   apply one step this edge
//   up_i     in   step direction: 1 = increment, 0 = decrement
//   ctr_o    out  current counter value
// ---------------------------------------------------------------------------
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             up_i,
    output logic [CTR_W-1:0] ctr_o
);

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;
    bp_ctr_t          ctr_wide;

    // The package helpers work on the widest counter type, so the value is
    // widened going in and truncated coming back; saturation is decided by
    // CTR_W, so the upper bits of the wide value are always zero.
    always_comb begin
        ctr_wide = bp_ctr_t'(ctr_q);
        ctr_d    = ctr_q;
        if (en_i) begin
            if (up_i) begin
                ctr_d = CTR_W'(bp_sat_inc(ctr_wide, CTR_W));
            end else begin
                ctr_d = CTR_W'(bp_sat_dec(ctr_wide, CTR_W));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/bp_counter_table.sv
// ---------------------------------------------------------------------------
// bp_counter_table
//
// Purpose:
//   Branch-direction predictor: 2^INDEX_W saturating counters plus a
//   non-speculative global history register (GHR). Lookups (from fetch) and
//   updates (from execute) use independent ports. In bimodal mode the table
//   is indexed by the PC bits; in gshare mode by PC XOR zero-extended history.
//
// Parameters:
//   INDEX_W  table index width, 1..10
//   CTR_W    counter width, 1..4
//   HIST_W   GHR width, 1..INDEX_W
//   MODE     BP_BIMODAL (0) or BP_GSHARE (1)
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   pred_valid  in   lookup request
//   pred_pc     in   PC index bits of the lookup
//   rsp_valid   out  response valid, one cycle after the request
//   rsp_taken   out  predicted direction (counter MSB)
//   rsp_ctr     out  counter value behind the prediction
//   rsp_hist    out  GHR snapshot taken with the request
//   upd_valid   in   resolved-branch update
//   upd_pc      in   PC index bits of the resolved branch
//   upd_hist    in   GHR snapshot that came back from rsp_hist
//   upd_taken   in   actual outcome
// ---------------------------------------------------------------------------
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int CTR_W   = 2,
    parameter int HIST_W  = 6,
    parameter int MODE    = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pred_valid,
    input  logic [INDEX_W-1:0] pred_pc,
    output logic               rsp_valid,
    output logic               rsp_taken,
    output logic [CTR_W-1:0]   rsp_ctr,
    output logic [HIST_W-1:0]  rsp_hist,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_pc,
    input  logic [HIST_W-1:0]  upd_hist,
    input  logic               upd_taken
);

    localparam int ENTRIES = 1 << INDEX_W;

    logic [HIST_W-1:0]  ghr_q;
    logic [HIST_W-1:0]  ghr_d;
    logic [HIST_W-1:0]  ghr_shift;

    logic [INDEX_W-1:0] pred_idx;
    logic [INDEX_W-1:0] upd_idx;

    logic [CTR_W-1:0]   ctr_tbl [ENTRIES];
    logic [ENTRIES-1:0] ctr_en;
    logic [CTR_W-1:0]   rd_ctr;

    logic               rsp_valid_q;
    logic               rsp_valid_d;
    logic               rsp_taken_q;
    logic               rsp_taken_d;
    logic [CTR_W-1:0]   rsp_ctr_q;
    logic [CTR_W-1:0]   rsp_ctr_d;
    logic [HIST_W-1:0]  rsp_hist_q;
    logic [HIST_W-1:0]  rsp_hist_d;

    // Index generation. The update side uses the snapshot carried down the
    // pipe, never the live GHR, so a branch trains the same entry that
    // predicted it even though the GHR has advanced since.
    generate
        if (MODE == BP_GSHARE) begin : g_gshare
            assign pred_idx = pred_pc ^ INDEX_W'(ghr_q);
            assign upd_idx  = upd_pc ^ INDEX_W'(upd_hist);
        end else begin : g_bimodal
            logic hist_unused;
            assign pred_idx    = pred_pc;
            assign upd_idx     = upd_pc;
            assign hist_unused = ^upd_hist;
        end
    endgenerate

    // Counter array: each entry is enabled only when the update index
    // decodes to it, so at most one counter moves per edge.
    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
            assign ctr_en[i] = upd_valid && (upd_idx == INDEX_W'(i));

            bp_sat_ctr #(
                .CTR_W (CTR_W)
            ) u_ctr (
                .clk     (clk),
                .reset_n (reset_n),
                .en_i    (ctr_en[i]),
                .up_i    (upd_taken),
                .ctr_o   (ctr_tbl[i])
            );
        end
    endgenerate

    // Read mux sees the registered counters, so a same-edge update is not
    // visible to the lookup; there is intentionally no bypass.
    assign rd_ctr = ctr_tbl[pred_idx];

    // History shift: newest outcome enters at the LSB.
    generate
        if (HIST_W == 1) begin : g_hist1
            assign ghr_shift = upd_taken;
        end else begin : g_histn
            assign ghr_shift = {ghr_q[HIST_W-2:0], upd_taken};
        end
    endgenerate

    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) begin
            ghr_d = ghr_shift;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // Response register: valid pulses for one cycle per request; the data
    // fields hold their last values while no request is present.
    always_comb begin
        rsp_valid_d = pred_valid;
        rsp_taken_d = rsp_taken_q;
        rsp_ctr_d   = rsp_ctr_q;
        rsp_hist_d  = rsp_hist_q;
        if (pred_valid) begin
            rsp_taken_d = bp_taken(bp_ctr_t'(rd_ctr), CTR_W);
            rsp_ctr_d   = rd_ctr;
            rsp_hist_d  = ghr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_taken_q <= 1'b0;
            rsp_ctr_q   <= '0;
            rsp_hist_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_taken_q <= rsp_taken_d;
            rsp_ctr_q   <= rsp_ctr_d;
            rsp_hist_q  <= rsp_hist_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_taken = rsp_taken_q;
    assign rsp_ctr   = rsp_ctr_q;
    assign rsp_hist  = rsp_hist_q;

endmodule

// File: tb/tb_bp_counter_table.sv
// ---------------------------------------------------------------------------
// tb_bp_counter_table
//
// Drives three predictor instances from one shared stimulus stream:
//   inst0: bimodal, INDEX_W=6, CTR_W=2, HIST_W=6
//   inst1: gshare,  INDEX_W=6, CTR_W=3, HIST_W=6
//   inst2: gshare,  INDEX_W=4, CTR_W=1, HIST_W=1
// A behavioural model (plain integer table + history integer) predicts every
// response; directed sections add literal expectations for the key cases.
// ---------------------------------------------------------------------------
module tb_bp_counter_table;

    localparam int NINST = 3;

    logic       clk;
    logic       reset_n;
    logic       predValid;
    logic [5:0] predPc;
    logic       updValid;
    logic [5:0] updPc;
    logic [5:0] updHist;
    logic       updTaken;

    logic       vA, tA, vB, tB, vC, tC;
    logic [1:0] cA;
    logic [2:0] cB;
    logic [0:0] cC;
    logic [5:0] hA, hB;
    logic [0:0] hC;

    int compareCount;
    int failCount;

    int idxW  [NINST];
    int ctrW  [NINST];
    int histW [NINST];
    int modeG [NINST];

    int mdlCtr [NINST][64];
    int mdlGhr [NINST];
    int expValid [NINST];
    int expTaken [NINST];
    int expCtr   [NINST];
    int expHist  [NINST];

    bp_counter_table #(.INDEX_W(6), .CTR_W(2), .HIST_W(6), .MODE(0)) dutA (
        .clk(clk), .reset_n(reset_n),
        .pred_valid(predValid), .pred_pc(predPc),
        .rsp_valid(vA), .rsp_taken(tA), .rsp_ctr(cA), .rsp_hist(hA),
        .upd_valid(updValid), .upd_pc(updPc), .upd_hist(updHist), .upd_taken(updTaken)
    );

    bp_counter_table #(.INDEX_W(6), .CTR_W(3), .HIST_W(6), .MODE(1)) dutB (
        .clk(clk), .reset_n(reset_n),
        .pred_valid(predValid), .pred_pc(predPc),
        .rsp_valid(vB), .rsp_taken(tB), .rsp_ctr(cB), .rsp_hist(hB),
        .upd_valid(updValid), .upd_pc(updPc), .upd_hist(updHist), .upd_taken(updTaken)
    );

    bp_counter_table #(.INDEX_W(4), .CTR_W(1), .HIST_W(1), .MODE(1)) dutC (
        .clk(clk), .reset_n(reset_n),
        .pred_valid(predValid), .pred_pc(predPc[3:0]),
        .rsp_valid(vC), .rsp_taken(tC), .rsp_ctr(cC), .rsp_hist(hC),
        .upd_valid(updValid), .upd_pc(updPc[3:0]), .upd_hist(updHist[0:0]), .upd_taken(updTaken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input int expv);
        compareCount++;
        if (obs !== 32'(expv)) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic getObs(input int k, output logic [31:0] v, output logic [31:0] t,
                          output logic [31:0] c, output logic [31:0] h);
        case (k)
            0:       begin v = 32'(vA); t = 32'(tA); c = 32'(cA); h = 32'(hA); end
            1:       begin v = 32'(vB); t = 32'(tB); c = 32'(cB); h = 32'(hB); end
            default: begin v = 32'(vC); t = 32'(tC); c = 32'(cC); h = 32'(hC); end
        endcase
    endtask

    task automatic modelReset();
        for (int k = 0; k < NINST; k++) begin
            for (int e = 0; e < 64; e++) mdlCtr[k][e] = 0;
            mdlGhr[k]   = 0;
            expValid[k] = 0;
            expTaken[k] = 0;
            expCtr[k]   = 0;
            expHist[k]  = 0;
        end
    endtask

    // Reference behaviour for one clock edge using the currently driven
    // inputs: the lookup sees the state before this edge's update.
    task automatic modelStep();
        for (int k = 0; k < NINST; k++) begin
            int iMask, hMask, cMax, pIdx, uIdx;
            iMask = (1 << idxW[k]) - 1;
            hMask = (1 << histW[k]) - 1;
            cMax  = (1 << ctrW[k]) - 1;
            pIdx  = (int'(predPc) & iMask) ^ ((modeG[k] == 1) ? mdlGhr[k] : 0);
            expValid[k] = int'(predValid);
            if (predValid) begin
                expCtr[k]   = mdlCtr[k][pIdx];
                expTaken[k] = (expCtr[k] >= (cMax + 1) / 2) ? 1 : 0;
                expHist[k]  = mdlGhr[k];
            end
            if (updValid) begin
                uIdx = (int'(updPc) & iMask) ^ ((modeG[k] == 1) ? (int'(updHist) & hMask) : 0);
                if (updTaken) begin
                    if (mdlCtr[k][uIdx] < cMax) mdlCtr[k][uIdx] = mdlCtr[k][uIdx] + 1;
                end else begin
                    if (mdlCtr[k][uIdx] > 0) mdlCtr[k][uIdx] = mdlCtr[k][uIdx] - 1;
                end
                mdlGhr[k] = ((mdlGhr[k] << 1) | int'(updTaken)) & hMask;
            end
        end
    endtask

    task automatic checkAll(input string phase);
        logic [31:0] v, t, c, h;
        for (int k = 0; k < NINST; k++) begin
            getObs(k, v, t, c, h);
            checkOutput($sformatf("%s inst%0d rsp_valid", phase, k), v, expValid[k]);
            checkOutput($sformatf("%s inst%0d rsp_taken", phase, k), t, expTaken[k]);
            checkOutput($sformatf("%s inst%0d rsp_ctr", phase, k), c, expCtr[k]);
            checkOutput($sformatf("%s inst%0d rsp_hist", phase, k), h, expHist[k]);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, and check after the edge.
    task automatic applyStimulus(input string phase, input logic pv, input logic [5:0] ppc,
                                 input logic uv, input logic [5:0] upc,
                                 input logic [5:0] uh, input logic ut);
        predValid = pv;
        predPc    = ppc;
        updValid  = uv;
        updPc     = upc;
        updHist   = uh;
        updTaken  = ut;
        modelStep();
        @(posedge clk);
        #1;
        checkAll(phase);
    endtask

    task automatic doReset(input string phase);
        predValid = 1'b0;
        predPc    = '0;
        updValid  = 1'b0;
        updPc     = '0;
        updHist   = '0;
        updTaken  = 1'b0;
        reset_n   = 1'b0;
        modelReset();
        #1;
        checkAll(phase);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        idxW  = '{6, 6, 4};
        ctrW  = '{2, 3, 1};
        histW = '{6, 6, 1};
        modeG = '{0, 1, 1};
        reset_n   = 1'b1;
        predValid = 1'b0;
        predPc    = '0;
        updValid  = 1'b0;
        updPc     = '0;
        updHist   = '0;
        updTaken  = 1'b0;
        modelReset();
        #2;

        // Reset values and first lookup.
        doReset("reset");
        checkOutput("reset rsp_valid", 32'(vA), 0);
        checkOutput("reset rsp_ctr", 32'(cA), 0);
        applyStimulus("first", 1'b1, 6'd5, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("first rsp_valid", 32'(vA), 1);
        checkOutput("first rsp_ctr", 32'(cA), 0);
        checkOutput("first rsp_taken", 32'(tA), 0);
        checkOutput("first rsp_hist", 32'(hA), 0);
        applyStimulus("first idle", 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("one-cycle rsp_valid", 32'(vA), 0);

        // Bimodal saturation in both directions.
        for (int i = 0; i < 4; i++) applyStimulus("bim up", 1'b0, 6'd0, 1'b1, 6'd3, 6'd0, 1'b1);
        applyStimulus("bim look", 1'b1, 6'd3, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("bim sat-high ctr", 32'(cA), 3);
        checkOutput("bim sat-high taken", 32'(tA), 1);
        applyStimulus("bim dn", 1'b0, 6'd0, 1'b1, 6'd3, 6'd0, 1'b0);
        applyStimulus("bim look", 1'b1, 6'd3, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("bim WT ctr", 32'(cA), 2);
        checkOutput("bim WT taken", 32'(tA), 1);
        for (int i = 0; i < 2; i++) applyStimulus("bim dn", 1'b0, 6'd0, 1'b1, 6'd3, 6'd0, 1'b0);
        applyStimulus("bim look", 1'b1, 6'd3, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("bim SNT ctr", 32'(cA), 0);
        applyStimulus("bim dn", 1'b0, 6'd0, 1'b1, 6'd3, 6'd0, 1'b0);
        applyStimulus("bim look", 1'b1, 6'd3, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("bim sat-low ctr", 32'(cA), 0);
        checkOutput("bim sat-low taken", 32'(tA), 0);

        // 3-bit counter saturation on the gshare instance.
        doReset("ctr3 reset");
        for (int i = 0; i < 5; i++) applyStimulus("ctr3 up", 1'b0, 6'd0, 1'b1, 6'd0, 6'd0, 1'b1);
        applyStimulus("ctr3 look", 1'b1, 6'd31, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("ctr3 five ctr", 32'(cB), 5);
        checkOutput("ctr3 five taken", 32'(tB), 1);
        checkOutput("ctr3 five hist", 32'(hB), 31);
        for (int i = 0; i < 3; i++) applyStimulus("ctr3 up", 1'b0, 6'd0, 1'b1, 6'd0, 6'd0, 1'b1);
        applyStimulus("ctr3 look", 1'b1, 6'd63, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("ctr3 max ctr", 32'(cB), 7);
        applyStimulus("ctr3 up", 1'b0, 6'd0, 1'b1, 6'd0, 6'd0, 1'b1);
        applyStimulus("ctr3 look", 1'b1, 6'd63, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("ctr3 held max ctr", 32'(cB), 7);

        // Gshare history and indexing.
        doReset("gsh reset");
        applyStimulus("gsh upd", 1'b0, 6'd0, 1'b1, 6'd10, 6'd0, 1'b1);
        applyStimulus("gsh upd", 1'b0, 6'd0, 1'b1, 6'd10, 6'd0, 1'b1);
        applyStimulus("gsh upd", 1'b0, 6'd0, 1'b1, 6'd20, 6'd0, 1'b0);
        applyStimulus("gsh look", 1'b1, 6'h05, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("gsh ghr snapshot", 32'(hB), 6);
        checkOutput("gsh entry3 ctr", 32'(cB), 0);
        applyStimulus("gsh upd3", 1'b0, 6'd0, 1'b1, 6'd5, 6'd6, 1'b1);
        applyStimulus("gsh look3", 1'b1, 6'd14, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("gsh entry3 after ctr", 32'(cB), 1);
        checkOutput("gsh ghr after", 32'(hB), 13);
        applyStimulus("gsh look5", 1'b1, 6'd8, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("gsh entry5 untouched", 32'(cB), 0);

        // Same-edge lookup and update: no bypass.
        doReset("same reset");
        applyStimulus("same pre", 1'b0, 6'd0, 1'b1, 6'd2, 6'd0, 1'b1);
        applyStimulus("same edge", 1'b1, 6'd2, 1'b1, 6'd2, 6'd0, 1'b1);
        checkOutput("same-edge old ctr", 32'(cA), 1);
        applyStimulus("same next", 1'b1, 6'd2, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("same-edge new ctr", 32'(cA), 2);

        // Reset while a response is in flight.
        for (int i = 0; i < 3; i++) applyStimulus("mid up", 1'b0, 6'd0, 1'b1, 6'd3, 6'd0, 1'b1);
        applyStimulus("mid look", 1'b1, 6'd3, 1'b0, 6'd0, 6'd0, 1'b0);
        checkOutput("mid pre rsp_valid", 32'(vA), 1);
        checkOutput("mid pre rsp_ctr", 32'(cA), 3);
        doReset("mid async");
        for (int p = 0; p < 64; p++) begin
            applyStimulus("post sweep", 1'b1, 6'(p), 1'b0, 6'd0, 6'd0, 1'b0);
            checkOutput("post-reset ctr", 32'(cA), 0);
        end
        checkOutput("post-reset ghr", 32'(hB), 0);

        // Randomized traffic checked against the model every cycle.
        for (int n = 0; n < 800; n++) begin
            logic       pv, uv, ut;
            logic [5:0] ppc, upc, uh;
            pv  = 1'($urandom_range(0, 1));
            uv  = ($urandom_range(0, 3) != 0);
            ut  = 1'($urandom_range(0, 1));
            ppc = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            upc = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            uh  = ($urandom_range(0, 1) == 1) ? 6'(mdlGhr[1]) : 6'($urandom);
            applyStimulus("random", pv, ppc, uv, upc, uh, ut);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
